// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: releases NUM_DOMAINS active-low domain resets in order
// after a hold delay, and re-runs the sequence on a software reset request.
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   all_released
);

  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   pending, pending_nxt;
  logic                   req_q, req_d;
  logic                   rise;
  logic                   rel_hit;
  logic                   take;
  logic [NUM_DOMAINS-1:0] dom_nxt;
  logic                   all_nxt;
  logic                   ack_nxt;

  // Request is registered once, then edge-detected against its previous sample.
  assign rise = req_q & ~req_d;

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state        <= S_HOLD;
      cnt          <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      req_q        <= 1'b0;
      req_d        <= 1'b0;
      dom_rst_n    <= '0;
      all_released <= 1'b0;
      sw_rst_ack   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      pending      <= pending_nxt;
      req_q        <= sw_rst_req;
      req_d        <= req_q;
      dom_rst_n    <= dom_nxt;
      all_released <= all_nxt;
      sw_rst_ack   <= ack_nxt;
    end
  end

  // Next-state: delay counting, domain stepping and software reset acceptance.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    pending_nxt = pending;
    rel_hit     = 1'b0;
    take        = 1'b0;
    case (state)
      S_HOLD: begin
        if (rise) pending_nxt = 1'b1;
        if (cnt == HOLD_LAST) begin
          rel_hit   = 1'b1;
          cnt_nxt   = '0;
          idx_nxt   = IDX_W'(1);
          state_nxt = (NUM_DOMAINS == 1) ? S_DONE : S_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (rise) pending_nxt = 1'b1;
        if (cnt == STEP_LAST) begin
          rel_hit = 1'b1;
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (rise || pending) begin
          take        = 1'b1;
          pending_nxt = 1'b0;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          state_nxt   = S_HOLD;
        end
      end
      default: begin
        state_nxt = S_HOLD;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output next values; the domain being released is the one at idx.
  always_comb begin
    dom_nxt = dom_rst_n;
    ack_nxt = take;
    all_nxt = (state_nxt == S_DONE);
    if (take) begin
      dom_nxt = '0;
    end else if (rel_hit) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (IDX_W'(i) == idx) dom_nxt[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default configuration plus a one-domain,
// one-cycle-hold instance, both checked against a release-time model.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       RST;
  logic       sw_rst_req;
  logic       ack0, all0, ack1, all1;
  logic [2:0] dom0;
  logic [0:0] dom1;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];

  rst_seq_ctrl #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .STEP_CYCLES(2), .CNT_W(8)) u_dut0 (
    .clk(clk), .RST(RST), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(ack0), .dom_rst_n(dom0), .all_released(all0)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STEP_CYCLES(2), .CNT_W(8)) u_dut1 (
    .clk(clk), .RST(RST), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(ack1), .dom_rst_n(dom1), .all_released(all1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from t = clk edges since the sequence (re)started:
  // domain k is free once t >= hold + k*step; all released once the last one is.
  function automatic logic [9:0] expect_out(input int n, input int h, input int s,
                                            input int t, input bit ack);
    logic [7:0] d;
    logic       all;
    d = '0;
    for (int k = 0; k < n; k++) begin
      if (t >= h + k * s) d[k] = 1'b1;
    end
    all = (t >= h + (n - 1) * s);
    return {ack, all, d};
  endfunction

  // One clock edge of the model. A request rise sampled at one edge acts at the next;
  // it is taken once the sequence is complete, otherwise remembered until then.
  task automatic model_step(input int n, input int h, input int s, input logic req,
                            inout int t, inout bit pend, inout bit s1, inout bit s2,
                            output bit ack);
    bit rise_seen;
    bit done;
    rise_seen = s1 & ~s2;
    done      = (t >= h + (n - 1) * s);
    s2        = s1;
    s1        = req;
    ack       = 1'b0;
    if (done && (rise_seen || pend)) begin
      t    = 0;
      pend = 1'b0;
      ack  = 1'b1;
    end else begin
      if (rise_seen) pend = 1'b1;
      if (t < 100000) t = t + 1;
    end
  endtask

  // Reference model: produces the expected post-edge outputs for both instances.
  int t0, t1;
  bit p0, p1, a0, b0, a1, b1, k0, k1;
  initial begin
    forever begin
      @(posedge clk or negedge RST);
      if (!RST) begin
        t0 = 0; p0 = 0; a0 = 0; b0 = 0;
        t1 = 0; p1 = 0; a1 = 0; b1 = 0;
        q0.delete(); q0.push_back(10'b0);
        q1.delete(); q1.push_back(10'b0);
      end else begin
        model_step(3, 4, 2, sw_rst_req, t0, p0, a0, b0, k0);
        model_step(1, 1, 2, sw_rst_req, t1, p1, a1, b1, k1);
        q0.delete(); q0.push_back(expect_out(3, 4, 2, t0, k0));
        q1.delete(); q1.push_back(expect_out(1, 1, 2, t1, k1));
      end
    end
  end

  // Monitor: compare DUT outputs against the pending expectations away from the edge.
  initial begin
    logic [9:0] e;
    logic [9:0] a;
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        a = {ack0, all0, 5'b0, dom0};
        chk_cnt++;
        if (a !== e) begin
          err_cnt++;
          $display("FAIL dut0 t=%0t ack/all/dom act=%b exp=%b", $time, a, e);
        end
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        a = {ack1, all1, 7'b0, dom1};
        chk_cnt++;
        if (a !== e) begin
          err_cnt++;
          $display("FAIL dut1 t=%0t ack/all/dom act=%b exp=%b", $time, a, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    RST = 1'b0;
    sw_rst_req = 1'b0;
    // power-on
    cyc(3); RST = 1'b1;
    // async assert between edges 5 and 6, then restart
    cyc(5); RST = 1'b0;
    cyc(2); RST = 1'b1;
    cyc(12);
    // single-cycle software request in DONE
    sw_rst_req = 1'b1; cyc(1); sw_rst_req = 1'b0;
    cyc(14);
    // request raised at edge 5 and held high
    RST = 1'b0; cyc(2); RST = 1'b1;
    cyc(4); sw_rst_req = 1'b1;
    cyc(25); sw_rst_req = 1'b0;
    cyc(3);
    // two pulses during HOLD merge into one
    RST = 1'b0; cyc(1); RST = 1'b1;
    sw_rst_req = 1'b1; cyc(1); sw_rst_req = 1'b0; cyc(1);
    sw_rst_req = 1'b1; cyc(1); sw_rst_req = 1'b0;
    cyc(20);
    // randomized requests with occasional async resets
    for (int i = 0; i < 600; i++) begin
      int roll;
      roll = int'($urandom_range(0, 99));
      if (roll < 3) begin
        RST = 1'b0;
        cyc(int'($urandom_range(1, 3)));
        RST = 1'b1;
      end else if (roll < 18) begin
        sw_rst_req = ~sw_rst_req;
      end
      cyc(1);
    end
    sw_rst_req = 1'b0;
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
